// File: rtl/exc_arbiter_if.sv
// Commit-stage to CP0 exception handoff bundle.
// master = pipeline/CP0 side driving commit info and ack, slave = exc_arbiter.
interface exc_arbiter_if #(
  parameter int EXC_W  = 18,
  parameter int TYPE_W = 5,
  parameter int ADDR_W = 32
);
  logic              commit_vld;
  logic              stall;
  logic              nullinst;
  logic [EXC_W-1:0]  excp_i;
  logic              d_refs;
  logic              in_dslot;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] m_vaddr;
  logic              cp0_ack;
  logic              exc_flag;
  logic              flush;
  logic              exc_req;
  logic [TYPE_W-1:0] exc_type;
  logic [ADDR_W-1:0] exc_baddr;
  logic              exc_save;
  logic [ADDR_W-1:0] exc_epc;
  logic              exc_bd;
  logic              redirect;
  logic [15:0]       exc_count;

  modport master (
    output commit_vld, stall, nullinst, excp_i, d_refs, in_dslot, pc, m_vaddr, cp0_ack,
    input  exc_flag, flush, exc_req, exc_type, exc_baddr, exc_save, exc_epc, exc_bd,
           redirect, exc_count
  );

  modport slave (
    input  commit_vld, stall, nullinst, excp_i, d_refs, in_dslot, pc, m_vaddr, cp0_ack,
    output exc_flag, flush, exc_req, exc_type, exc_baddr, exc_save, exc_epc, exc_bd,
           redirect, exc_count
  );
endinterface

// File: rtl/exc_arbiter.sv
// Commit-stage exception arbiter: picks the highest-priority exception,
// latches its record and hands it to CP0 while the pipeline is flushed.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | no record pending; capture on exc_flag & ~stall
//  WAIT_ACK | record held for CP0, flush asserted, new exceptions ignored
//  REDIR    | one-cycle redirect pulse to fetch, flush still asserted
module exc_arbiter #(
  parameter int                        EXC_W      = 18,
  parameter int                        TYPE_W     = 5,
  parameter int                        ADDR_W     = 32,
  parameter logic [EXC_W*TYPE_W-1:0]   TYPE_TABLE = {5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13,
                                                     5'd12, 5'd11, 5'd10, 5'd9,  5'd8,  5'd7,
                                                     5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1},
  parameter logic [EXC_W-1:0]          BADDR_PC   = 18'h0001C,
  parameter logic [EXC_W-1:0]          BADDR_MEM  = 18'h0F000,
  parameter logic [TYPE_W-1:0]         NOEXC_CODE = '0
) (
  input logic          clk,
  input logic          rst,
  exc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, REDIR} state_t;

  state_t            state_q, state_d;
  logic [EXC_W-1:0]  q;
  logic              flag;
  logic              capture;
  logic [TYPE_W-1:0] type_c;
  logic              pc_sel, mem_sel;
  logic [ADDR_W-1:0] baddr_c;
  logic              save_c;
  logic [ADDR_W-1:0] epc_c;

  logic [TYPE_W-1:0] type_q;
  logic [ADDR_W-1:0] baddr_q;
  logic              save_q;
  logic [ADDR_W-1:0] epc_q;
  logic              bd_q;
  logic [15:0]       cnt_q;

  assign q    = bus.excp_i & {EXC_W{bus.commit_vld & ~bus.nullinst}};
  assign flag = |q;

  // Priority select: scan high to low so the lowest set bit is written last and wins.
  always_comb begin
    type_c  = NOEXC_CODE;
    pc_sel  = 1'b0;
    mem_sel = 1'b0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (q[i]) begin
        type_c  = TYPE_TABLE[i*TYPE_W +: TYPE_W];
        pc_sel  = BADDR_PC[i];
        mem_sel = BADDR_MEM[i];
      end
    end
  end

  // Bad address / save flag; a pc-sourced fault never flags a data reference.
  always_comb begin
    baddr_c = '0;
    save_c  = bus.d_refs;
    if (pc_sel) begin
      baddr_c = bus.pc;
      save_c  = 1'b0;
    end else if (mem_sel) begin
      baddr_c = bus.m_vaddr;
    end
    epc_c = bus.in_dslot ? (bus.pc - ADDR_W'(4)) : bus.pc;
  end

  // Next-state logic; ack only matters while a record is pending.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (flag && !bus.stall) begin
          capture = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: if (bus.cp0_ack) state_d = REDIR;
      REDIR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Exception record and saturating accept counter, loaded only on the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q  <= NOEXC_CODE;
      baddr_q <= '0;
      save_q  <= 1'b0;
      epc_q   <= '0;
      bd_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (capture) begin
      type_q  <= type_c;
      baddr_q <= baddr_c;
      save_q  <= save_c;
      epc_q   <= epc_c;
      bd_q    <= bus.in_dslot;
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.exc_flag  = flag;
  assign bus.exc_req   = (state_q == WAIT_ACK);
  assign bus.flush     = (state_q == WAIT_ACK) || (state_q == REDIR);
  assign bus.redirect  = (state_q == REDIR);
  assign bus.exc_type  = type_q;
  assign bus.exc_baddr = baddr_q;
  assign bus.exc_save  = save_q;
  assign bus.exc_epc   = epc_q;
  assign bus.exc_bd    = bd_q;
  assign bus.exc_count = cnt_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: vector table plus hand sequences for the handshake,
// reset abort and counter saturation. Expected records go through a queue.
module tb_exc_arbiter;
  localparam int EXC_W  = 18;
  localparam int TYPE_W = 5;
  localparam int ADDR_W = 32;
  localparam int NV     = 10;

  function automatic logic [TYPE_W-1:0] tcode(int i);
    return TYPE_W'((i * 5 + 3) % 32);
  endfunction

  function automatic logic [EXC_W*TYPE_W-1:0] build_table();
    logic [EXC_W*TYPE_W-1:0] t;
    t = '0;
    for (int i = 0; i < EXC_W; i++) t[i*TYPE_W +: TYPE_W] = tcode(i);
    return t;
  endfunction

  localparam logic [EXC_W*TYPE_W-1:0] TT = build_table();

  typedef struct {
    logic [EXC_W-1:0]  excp;
    logic              vld, nul, stl, dref, dsl;
    logic [ADDR_W-1:0] pc, va;
    logic              flag, cap;
    logic [TYPE_W-1:0] typ;
    logic [ADDR_W-1:0] baddr;
    logic              save;
    logic [ADDR_W-1:0] epc;
    logic              bd;
  } vec_t;

  typedef struct {
    logic [TYPE_W-1:0] typ;
    logic [ADDR_W-1:0] baddr;
    logic              save;
    logic [ADDR_W-1:0] epc;
    logic              bd;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  vec_t vecs[NV];
  rec_t sb[$];

  exc_arbiter_if #(.EXC_W(EXC_W), .TYPE_W(TYPE_W), .ADDR_W(ADDR_W)) bus ();

  exc_arbiter #(
    .EXC_W(EXC_W), .TYPE_W(TYPE_W), .ADDR_W(ADDR_W), .TYPE_TABLE(TT),
    .BADDR_PC(18'h0001C), .BADDR_MEM(18'h0F000), .NOEXC_CODE(5'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.commit_vld = 1'b0; bus.stall = 1'b0; bus.nullinst = 1'b0;
    bus.excp_i = '0; bus.d_refs = 1'b0; bus.in_dslot = 1'b0;
    bus.pc = '0; bus.m_vaddr = '0; bus.cp0_ack = 1'b0;
  endtask

  task automatic drive(vec_t v);
    bus.excp_i = v.excp; bus.commit_vld = v.vld; bus.nullinst = v.nul;
    bus.stall = v.stl; bus.d_refs = v.dref; bus.in_dslot = v.dsl;
    bus.pc = v.pc; bus.m_vaddr = v.va;
  endtask

  task automatic push_exp(vec_t v);
    rec_t r;
    r.typ = v.typ; r.baddr = v.baddr; r.save = v.save; r.epc = v.epc; r.bd = v.bd;
    sb.push_back(r);
    if (exp_cnt < 65535) exp_cnt++;
  endtask

  // Called in a cycle where the DUT presents a record; compare against the queue head.
  task automatic pop_compare();
    rec_t r;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got exc_req=1 expected no pending record");
    end else begin
      r = sb.pop_front();
      chk("type",  64'(bus.exc_type),  64'(r.typ));
      chk("baddr", 64'(bus.exc_baddr), 64'(r.baddr));
      chk("save",  64'(bus.exc_save),  64'(r.save));
      chk("epc",   64'(bus.exc_epc),   64'(r.epc));
      chk("bd",    64'(bus.exc_bd),    64'(r.bd));
    end
  endtask

  // One vector from IDLE: check flag, capture outcome and, if captured, the ack/redirect tail.
  task automatic apply(vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk("flag", 64'(bus.exc_flag), 64'(v.flag));
    if (v.cap) push_exp(v);
    @(negedge clk);
    idle_inputs();
    chk("req",   64'(bus.exc_req), 64'(v.cap));
    chk("flush", 64'(bus.flush),   64'(v.cap));
    chk("count", 64'(bus.exc_count), 64'(exp_cnt));
    if (bus.exc_req) pop_compare();
    else if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_lost: got exc_req=0 expected a pending record");
      sb.delete();
    end
    if (v.cap) begin
      bus.cp0_ack = 1'b1;
      @(negedge clk);
      bus.cp0_ack = 1'b0;
      chk("redir_hi",   64'(bus.redirect), 64'(1));
      chk("req_redir",  64'(bus.exc_req),  64'(0));
      chk("flush_redir", 64'(bus.flush),   64'(1));
      @(negedge clk);
      chk("redir_lo", 64'(bus.redirect), 64'(0));
      chk("flush_lo", 64'(bus.flush),    64'(0));
    end
  endtask

  initial begin
    //        excp        vld   nul   stl   dref  dsl   pc             va              flag  cap   type       baddr          save  epc            bd
    vecs[0] = '{18'h00004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0000_0000, 1'b1, 1'b1, tcode(2),  32'h8000_0100, 1'b0, 32'h8000_0100, 1'b0};
    vecs[1] = '{18'h01102, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_1234, 1'b1, 1'b1, tcode(1),  32'h0000_0000, 1'b1, 32'h0000_0400, 1'b0};
    vecs[2] = '{18'h01000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_1234, 1'b1, 1'b1, tcode(12), 32'h0000_1234, 1'b1, 32'h0000_0400, 1'b0};
    vecs[3] = '{18'h00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, tcode(0),  32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b1};
    vecs[4] = '{18'h00020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0044, 1'b0, 1'b0, 5'h00,     32'h0,         1'b0, 32'h0,         1'b0};
    vecs[5] = '{18'h00008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_0044, 1'b1, 1'b0, 5'h00,     32'h0,         1'b0, 32'h0,         1'b0};
    vecs[6] = '{18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0044, 1'b0, 1'b0, 5'h00,     32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7] = '{18'h20000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0008, 32'h0000_5555, 1'b1, 1'b1, tcode(17), 32'h0000_0000, 1'b0, 32'h2000_0004, 1'b1};
    vecs[8] = '{18'h0F018, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEE0, 32'h0000_7777, 1'b1, 1'b1, tcode(3),  32'hDEAD_BEE0, 1'b0, 32'hDEAD_BEE0, 1'b0};
    vecs[9] = '{18'h08000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b1, tcode(15), 32'hCAFE_F00D, 1'b0, 32'h0000_0040, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req",   64'(bus.exc_req),   64'(0));
    chk("rst_flush", 64'(bus.flush),     64'(0));
    chk("rst_redir", 64'(bus.redirect),  64'(0));
    chk("rst_type",  64'(bus.exc_type),  64'(0));
    chk("rst_count", 64'(bus.exc_count), 64'(0));
    chk("rst_flag",  64'(bus.exc_flag),  64'(0));
    rst = 1'b0;

    for (int k = 0; k < NV; k++) apply(vecs[k]);

    // Ack coincident with capture is ignored; record then held for 5 cycles despite new inputs.
    @(negedge clk);
    drive(vecs[0]);
    bus.cp0_ack = 1'b1;
    push_exp(vecs[0]);
    @(negedge clk);
    bus.cp0_ack = 1'b0;
    chk("early_ack_req",   64'(bus.exc_req),  64'(1));
    chk("early_ack_redir", 64'(bus.redirect), 64'(0));
    if (bus.exc_req) pop_compare();
    bus.excp_i = 18'h00010; bus.pc = 32'h1111_2220; bus.in_dslot = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_req",   64'(bus.exc_req),   64'(1));
      chk("hold_flush", 64'(bus.flush),     64'(1));
      chk("hold_redir", 64'(bus.redirect),  64'(0));
      chk("hold_type",  64'(bus.exc_type),  64'(tcode(2)));
      chk("hold_epc",   64'(bus.exc_epc),   64'(32'h8000_0100));
      chk("hold_count", 64'(bus.exc_count), 64'(exp_cnt));
    end
    bus.cp0_ack = 1'b1;
    @(negedge clk);
    bus.cp0_ack = 1'b0;
    chk("ack_redir", 64'(bus.redirect), 64'(1));
    chk("ack_req",   64'(bus.exc_req),  64'(0));
    idle_inputs();
    @(negedge clk);
    chk("post_redir", 64'(bus.redirect),  64'(0));
    chk("post_req",   64'(bus.exc_req),   64'(0));
    chk("post_count", 64'(bus.exc_count), 64'(exp_cnt));

    // Reset while waiting for ack aborts with no redirect.
    @(negedge clk);
    drive(vecs[7]);
    push_exp(vecs[7]);
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_req", 64'(bus.exc_req), 64'(1));
    if (bus.exc_req) pop_compare();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("abort_req",   64'(bus.exc_req),   64'(0));
    chk("abort_flush", 64'(bus.flush),     64'(0));
    chk("abort_redir", 64'(bus.redirect),  64'(0));
    chk("abort_type",  64'(bus.exc_type),  64'(0));
    chk("abort_baddr", 64'(bus.exc_baddr), 64'(0));
    chk("abort_epc",   64'(bus.exc_epc),   64'(0));
    chk("abort_bd",    64'(bus.exc_bd),    64'(0));
    chk("abort_count", 64'(bus.exc_count), 64'(0));
    @(negedge clk);
    chk("abort_redir2", 64'(bus.redirect), 64'(0));

    // Counter saturation: preload near the top, then take two exceptions.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    chk("preload", 64'(bus.exc_count), 64'(16'hFFFE));
    apply(vecs[9]);
    chk("sat_top", 64'(bus.exc_count), 64'(16'hFFFF));
    apply(vecs[1]);
    chk("sat_hold", 64'(bus.exc_count), 64'(16'hFFFF));

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_leftover: got %0d pending records expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
